// File: rtl/adpll_phase_step_sequencer.sv
// ADPLL phase-step sequencer: selects a reference phase, measures time-to-lock
// and peak |error| per step, in single-step or automatic-sweep mode.
module adpll_phase_step_sequencer #(
  parameter int ERR_W       = 8,
  parameter int N_PHASES    = 4,
  parameter int SEL_W       = 2,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int CNT_W       = 12,
  parameter int TIMEOUT     = 4095
) (
  input  logic               fpga_clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   manual_sel_i,
  input  logic [ERR_W-1:0]   error_i,
  input  logic               error_valid_i,
  output logic [SEL_W-1:0]   ref_sel_o,
  output logic               busy_o,
  output logic               locked_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [SEL_W-1:0]   step_idx_o,
  output logic [CNT_W-1:0]   lock_time_o,
  output logic [ERR_W-2:0]   peak_err_o
);
  localparam int RUN_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_PHASES - 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
  localparam logic [ERR_W-2:0] MAG_MAX  = '1;
  localparam logic [ERR_W-2:0] THRESH   = (ERR_W-1)'(LOCK_THRESH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, REPORT = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [RUN_W-1:0]   run_cnt, run_nxt;
  logic [CNT_W-1:0]   smp_cnt, smp_nxt;
  logic [ERR_W-2:0]   peak, mag;
  logic               auto_mode, to_pend;
  logic               in_band, lock_hit, to_hit, start_go, advance, enter_acq;

  // Most negative input has no positive twin in ERR_W bits, so it saturates.
  function automatic logic [ERR_W-2:0] abs_sat(input logic [ERR_W-1:0] e);
    logic [ERR_W-1:0] neg;
    neg = -e;
    if (!e[ERR_W-1]) begin
      return e[ERR_W-2:0];
    end else if (neg[ERR_W-1]) begin
      return MAG_MAX;
    end else begin
      return neg[ERR_W-2:0];
    end
  endfunction

  always_comb begin
    mag       = abs_sat(error_i);
    in_band   = (mag <= THRESH);
    run_nxt   = '0;
    if (in_band) begin
      run_nxt = (run_cnt == LOCK_RUN) ? LOCK_RUN : run_cnt + RUN_W'(1);
    end else begin
      run_nxt = '0;
    end
    smp_nxt   = smp_cnt + CNT_W'(1);
    lock_hit  = error_valid_i && (run_nxt == LOCK_RUN);
    to_hit    = error_valid_i && (smp_nxt == TO_CNT);
    start_go  = start_i && !abort_i;
    advance   = auto_mode && (ref_sel_o < LAST_SEL);
    enter_acq = ((state == IDLE) && start_go) ||
                ((state == REPORT) && !abort_i && advance);
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_go ? ACQUIRE : IDLE;
      ACQUIRE: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (lock_hit || to_hit) begin
          state_nxt = REPORT;
        end else begin
          state_nxt = ACQUIRE;
        end
      end
      REPORT: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (advance) begin
          state_nxt = ACQUIRE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An abort during REPORT suppresses the pulse, so done_o looks at abort_i.
  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == REPORT) && !abort_i;
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      run_cnt     <= '0;
      locked_o    <= 1'b0;
      ref_sel_o   <= '0;
      auto_mode   <= 1'b0;
      smp_cnt     <= '0;
      peak        <= '0;
      to_pend     <= 1'b0;
      step_idx_o  <= '0;
      lock_time_o <= '0;
      peak_err_o  <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if (enter_acq) begin
        run_cnt  <= '0;
        locked_o <= 1'b0;
        smp_cnt  <= '0;
        peak     <= '0;
      end else begin
        if (error_valid_i) begin
          run_cnt  <= run_nxt;
          locked_o <= (run_nxt == LOCK_RUN);
        end
        if ((state == ACQUIRE) && error_valid_i) begin
          smp_cnt <= smp_nxt;
          if (mag > peak) begin
            peak <= mag;
          end
          to_pend <= !lock_hit;
        end
      end
      if ((state == IDLE) && start_go) begin
        auto_mode <= mode_i;
        ref_sel_o <= mode_i ? '0 : ((manual_sel_i > LAST_SEL) ? LAST_SEL : manual_sel_i);
      end else if ((state == REPORT) && !abort_i && advance) begin
        ref_sel_o <= ref_sel_o + SEL_W'(1);
      end
      // The sample counter already holds the lock time (or TIMEOUT) on REPORT.
      if ((state == REPORT) && !abort_i) begin
        step_idx_o  <= ref_sel_o;
        lock_time_o <= smp_cnt;
        peak_err_o  <= peak;
        timeout_o   <= to_pend;
      end
    end
  end
endmodule

// File: tb/tb_adpll_phase_step_sequencer.sv
// Directed bench for adpll_phase_step_sequencer: cycle table plus sequences
// for auto sweep, timeout and mid-step reset. SEL_W=3 so clamping is reachable.
module tb_adpll_phase_step_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, abort, mode, valid;
  logic [2:0] sel;
  logic [7:0] err;
  logic [2:0] ref_sel, step_idx;
  logic       busy, locked, done, tout;
  logic [11:0] lock_time;
  logic [6:0] peak_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adpll_phase_step_sequencer #(
    .ERR_W(8), .N_PHASES(4), .SEL_W(3), .LOCK_THRESH(2),
    .LOCK_CYCLES(16), .CNT_W(12), .TIMEOUT(4095)
  ) dut (
    .fpga_clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .mode_i(mode), .manual_sel_i(sel), .error_i(err), .error_valid_i(valid),
    .ref_sel_o(ref_sel), .busy_o(busy), .locked_o(locked), .done_o(done),
    .timeout_o(tout), .step_idx_o(step_idx), .lock_time_o(lock_time),
    .peak_err_o(peak_err)
  );

  typedef struct {
    int rep; int st; int ab; int md; int sl; int er; int vl;
    int bz; int lk; int dn; int rf;
    int ck; int ix; int tm; int pk; int to;
  } vec_t;

  vec_t vec[64];
  int   nv = 0;

  task automatic add(input int rep, st, ab, md, sl, er, vl, bz, lk, dn, rf,
                     ck, ix, tm, pk, to);
    vec[nv] = '{rep, st, ab, md, sl, er, vl, bz, lk, dn, rf, ck, ix, tm, pk, to};
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input int ix, tm, pk, to);
    check({tag, " step_idx"},  32'(step_idx),  32'(ix));
    check({tag, " lock_time"}, 32'(lock_time), 32'(tm));
    check({tag, " peak_err"},  32'(peak_err),  32'(pk));
    check({tag, " timeout"},   32'(tout),      32'(to));
  endtask

  initial begin
    int ndone, pend, k;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    sel = 3'd0; err = 8'd0; valid = 1'b0;
    tick; tick;
    reset = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst locked", 32'(locked), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ref_sel", 32'(ref_sel), 32'd0);
    check_results("rst", 0, 0, 0, 0);

    // rep st ab md sl er vl | bz lk dn rf | ck ix tm pk to
    // manual sel 2, sixteen samples of +1
    add(1,  1, 0, 0, 2, 1,   0,  1, 0, 0, 2,  0, 0, 0, 0, 0);
    add(15, 0, 0, 0, 2, 1,   1,  1, 0, 0, 2,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 2, 1,   1,  1, 1, 1, 2,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   0,  0, 1, 0, 2,  1, 2, 16, 1, 0);
    // manual sel 1: -5, +3, then sixteen zeros
    add(1,  1, 0, 0, 1, 0,   0,  1, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 251, 1,  1, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 3,   1,  1, 0, 0, 1,  0, 0, 0, 0, 0);
    add(15, 0, 0, 0, 0, 0,   1,  1, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   1,  1, 1, 1, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   0,  0, 1, 0, 1,  1, 1, 18, 5, 0);
    // manual sel 7 clamps to 3; a start (auto) while busy is ignored
    add(1,  1, 0, 0, 7, 0,   0,  1, 0, 0, 3,  0, 0, 0, 0, 0);
    add(1,  1, 0, 1, 0, 0,   1,  1, 0, 0, 3,  0, 0, 0, 0, 0);
    add(14, 0, 0, 0, 0, 0,   1,  1, 0, 0, 3,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   1,  1, 1, 1, 3,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   0,  0, 1, 0, 3,  1, 3, 16, 0, 0);
    // auto sweep aborted during step 1 (abort also beats start)
    add(1,  1, 0, 1, 2, 0,   0,  1, 0, 0, 0,  0, 0, 0, 0, 0);
    add(15, 0, 0, 0, 0, 0,   1,  1, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   1,  1, 1, 1, 0,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   1,  1, 0, 0, 1,  1, 0, 16, 0, 0);
    add(5,  0, 0, 0, 0, 0,   1,  1, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1,  1, 1, 0, 0, 0,   1,  0, 0, 0, 1,  1, 0, 16, 0, 0);
    add(1,  0, 0, 0, 0, 0,   0,  0, 0, 0, 1,  1, 0, 16, 0, 0);

    for (int i = 0; i < nv; i++) begin
      for (int r = 0; r < vec[i].rep; r++) begin
        start = 1'(vec[i].st); abort = 1'(vec[i].ab); mode = 1'(vec[i].md);
        sel = 3'(vec[i].sl); err = 8'(vec[i].er); valid = 1'(vec[i].vl);
        tick;
        check($sformatf("v%0d busy", i),    32'(busy),    32'(vec[i].bz));
        check($sformatf("v%0d locked", i),  32'(locked),  32'(vec[i].lk));
        check($sformatf("v%0d done", i),    32'(done),    32'(vec[i].dn));
        check($sformatf("v%0d ref_sel", i), 32'(ref_sel), 32'(vec[i].rf));
        if (vec[i].ck != 0)
          check_results($sformatf("v%0d", i), vec[i].ix, vec[i].tm, vec[i].pk, vec[i].to);
      end
    end
    start = 1'b0; abort = 1'b0; valid = 1'b0;

    // auto sweep over all four phases with error held at zero
    start = 1'b1; mode = 1'b1; tick; start = 1'b0; mode = 1'b0;
    valid = 1'b1; err = 8'd0;
    ndone = 0; pend = 0;
    for (int c = 0; c < 200; c++) begin
      tick;
      if (pend != 0) begin
        check_results($sformatf("sweep%0d", ndone - 1), ndone - 1, 16, 0, 0);
        pend = 0;
        if (ndone == 4) break;
      end
      if (done) begin
        check($sformatf("sweep%0d ref_sel", ndone), 32'(ref_sel), 32'(ndone));
        ndone++;
        pend = 1;
      end
    end
    check("sweep done count", 32'(ndone), 32'd4);
    check("sweep idle busy", 32'(busy), 32'd0);
    valid = 1'b0;
    tick;

    // constant -128 never locks: timeout after 4095 samples
    start = 1'b1; sel = 3'd0; tick; start = 1'b0;
    valid = 1'b1; err = 8'h80;
    k = 0;
    for (int c = 1; c <= 5000; c++) begin
      tick;
      if (done) begin
        k = c;
        break;
      end
    end
    check("timeout samples", 32'(k), 32'd4095);
    check("timeout locked", 32'(locked), 32'd0);
    valid = 1'b0;
    tick;
    check_results("timeout", 0, 4095, 127, 1);
    check("timeout idle", 32'(busy), 32'd0);

    // reset in the middle of ACQUIRE
    start = 1'b1; sel = 3'd2; tick; start = 1'b0;
    valid = 1'b1; err = 8'd9;
    tick; tick; tick;
    valid = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid-rst busy", 32'(busy), 32'd0);
    check("mid-rst ref_sel", 32'(ref_sel), 32'd0);
    check("mid-rst done", 32'(done), 32'd0);
    check_results("mid-rst", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
